// File: rtl/pb_seq_conditioner.sv
// Push-button conditioner: sync + debounce + single press pulse; optional PB_AUTOREPEAT_EN hold-repeat.
// Latency: press pulse is high for the cycle after edge DEBOUNCE_CYCLES+3 (edge 1 = first edge seeing the new raw level).
// Backpressure: none; pulses are fire-and-forget, and presses colliding with the other button are suppressed.
module pb_seq_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic key_up_raw,
  input  logic key_dn_raw,
  output logic pb_seq_up,
  output logic pb_seq_dn,
  output logic up_level,
  output logic dn_level,
  output logic conflict
);

  localparam logic             POL     = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the up channel, bit 1 the down channel throughout.
  logic [1:0]       raw;
  logic [1:0]       s1, s2;
  logic [1:0]       st, st_prev;
  logic [1:0]       rise, fire, rpt_fire;
  logic [CNT_W-1:0] cnt [2];

  assign raw = {key_dn_raw, key_up_raw} ^ {2{POL}};

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      st      <= '0;
      st_prev <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      st_prev <= st;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          st[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press only counts if the other button neither rose with it nor was already held.
  assign rise    = st & ~st_prev;
  assign fire[0] = rise[0] & ~rise[1] & ~st_prev[1];
  assign fire[1] = rise[1] & ~rise[0] & ~st_prev[0];

`ifdef PB_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_RATE);

  logic [1:0]       rpt_act, rpt_first, solo;
  logic [CNT_W-1:0] rcnt [2];

  assign solo = {st[1] & ~st[0], st[0] & ~st[1]};

  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < 2; i++)
      rpt_fire[i] = rpt_act[i] & solo[i] &
                    (rcnt[i] == (rpt_first[i] ? RPT_FIRST : RPT_NEXT));
  end

  // rcnt holds cycles since the last emitted pulse (1 on the cycle the pulse is visible).
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      rpt_act   <= '0;
      rpt_first <= '0;
      for (int i = 0; i < 2; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fire[i]) begin
          rpt_act[i]   <= 1'b1;
          rpt_first[i] <= 1'b1;
          rcnt[i]      <= CNT_W'(1);
        end else if (!rpt_act[i] || !solo[i]) begin
          rpt_act[i]   <= 1'b0;
          rpt_first[i] <= 1'b0;
          rcnt[i]      <= '0;
        end else if (rpt_fire[i]) begin
          rpt_first[i] <= 1'b0;
          rcnt[i]      <= CNT_W'(1);
        end else begin
          rcnt[i]      <= rcnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

  // Scope exists only when CNT_W cannot hold the debounce or repeat counts.
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) || (64'd1 << CNT_W) <= 64'(REPEAT_DELAY) ||
      (64'd1 << CNT_W) <= 64'(REPEAT_RATE) || DEBOUNCE_CYCLES < 1) begin : g_cnt_w_too_small
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      pb_seq_up <= 1'b0;
      pb_seq_dn <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      pb_seq_up <= fire[0] | rpt_fire[0];
      pb_seq_dn <= fire[1] | rpt_fire[1];
      conflict  <= st[0] & st[1];
    end
  end

  assign up_level = st[0];
  assign dn_level = st[1];

endmodule

// File: tb/tb_pb_seq_conditioner.sv
// Directed bench for pb_seq_conditioner with DEBOUNCE_CYCLES=8, active-low buttons.
module tb_pb_seq_conditioner;

  logic CLK_50 = 1'b0;
  logic reset;
  logic key_up_raw, key_dn_raw;
  logic pb_seq_up, pb_seq_dn, up_level, dn_level, conflict;

`ifdef PB_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  pb_seq_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (8),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (40),
    .REPEAT_RATE    (10)
  ) dut (
    .CLK_50    (CLK_50),
    .reset     (reset),
    .key_up_raw(key_up_raw),
    .key_dn_raw(key_dn_raw),
    .pb_seq_up (pb_seq_up),
    .pb_seq_dn (pb_seq_dn),
    .up_level  (up_level),
    .dn_level  (dn_level),
    .conflict  (conflict)
  );

  initial forever #10 CLK_50 = ~CLK_50;

  int n_tests = 0;
  int n_fail  = 0;

  // Edge counter and pulse monitor
  int cyc = 0;
  int up_pulses = 0, dn_pulses = 0;
  int last_up_cyc = -1, last_dn_cyc = -1;
  int wide_cnt = 0, both_cnt = 0;
  logic prev_up = 1'b0, prev_dn = 1'b0;

  always @(posedge CLK_50) cyc <= cyc + 1;

  always @(negedge CLK_50) begin
    if (pb_seq_up) begin
      up_pulses   <= up_pulses + 1;
      last_up_cyc <= cyc;
    end
    if (pb_seq_dn) begin
      dn_pulses   <= dn_pulses + 1;
      last_dn_cyc <= cyc;
    end
    if ((pb_seq_up && prev_up) || (pb_seq_dn && prev_dn)) wide_cnt <= wide_cnt + 1;
    if (pb_seq_up && pb_seq_dn) both_cnt <= both_cnt + 1;
    prev_up <= pb_seq_up;
    prev_dn <= pb_seq_dn;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_50);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic up_raw;
    logic dn_raw;
    int   cycles;
    int   exp_up_p;
    int   exp_dn_p;
    logic exp_up_lvl;
    logic exp_dn_lvl;
    logic exp_conf;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int u0, d0, base, base2;

    tbl[0]  = '{1'b1, 1'b1, 20, 0, 0, 1'b0, 1'b0, 1'b0};  // idle
    tbl[1]  = '{1'b0, 1'b1, 30, 1, 0, 1'b1, 1'b0, 1'b0};  // up press
    tbl[2]  = '{1'b1, 1'b1, 30, 0, 0, 1'b0, 1'b0, 1'b0};  // release: no pulse
    tbl[3]  = '{1'b1, 1'b0, 30, 0, 1, 1'b0, 1'b1, 1'b0};  // dn press
    tbl[4]  = '{1'b0, 1'b0, 30, 0, 0, 1'b1, 1'b1, 1'b1};  // up while dn held
    tbl[5]  = '{1'b1, 1'b0, 30, 0, 0, 1'b0, 1'b1, 1'b0};  // drop up, dn held
    tbl[6]  = '{1'b1, 1'b1, 30, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 30, 0, 0, 1'b1, 1'b1, 1'b1};  // simultaneous
    tbl[8]  = '{1'b0, 1'b1, 30, 0, 0, 1'b1, 1'b0, 1'b0};  // drop dn, up held
    tbl[9]  = '{1'b1, 1'b1, 30, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 7,  0, 0, 1'b0, 1'b0, 1'b0};  // 7-cycle glitch
    tbl[11] = '{1'b1, 1'b1, 30, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8,  0, 0, 1'b0, 1'b0, 1'b0};  // 8-cycle press
    tbl[13] = '{1'b1, 1'b1, 30, 1, 0, 1'b0, 1'b0, 1'b0};  // ...accepted late

    reset = 1'b1;
    key_up_raw = 1'b1;
    key_dn_raw = 1'b1;
    tick(3);
    check("reset pb_seq_up", int'(pb_seq_up), 0);
    check("reset pb_seq_dn", int'(pb_seq_dn), 0);
    check("reset up_level", int'(up_level), 0);
    check("reset dn_level", int'(dn_level), 0);
    check("reset conflict", int'(conflict), 0);
    reset = 1'b0;
    tick(5);

    // Clean press with exact latency
    u0 = up_pulses; d0 = dn_pulses;
    key_up_raw = 1'b0; base = cyc;
    tick(9);
    check("clean up_level@9", int'(up_level), 0);
    tick(1);
    check("clean up_level@10", int'(up_level), 1);
    check("clean pulse@10", int'(pb_seq_up), 0);
    tick(1);
    check("clean pulse@11", int'(pb_seq_up), 1);
    tick(1);
    check("clean pulse@12", int'(pb_seq_up), 0);
    tick(28);
    key_up_raw = 1'b1;
    tick(30);
    check("clean up count", up_pulses - u0, 1);
    check("clean dn count", dn_pulses - d0, 0);
    check("clean up edge", last_up_cyc - base, 11);
    check("clean release level", int'(up_level), 0);

    // Bounce on dn: toggle every 3 cycles for 30, then hold
    d0 = dn_pulses;
    for (int seg = 0; seg < 10; seg++) begin
      key_dn_raw = (seg % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    key_dn_raw = 1'b0; base = cyc;
    tick(20);
    check("bounce dn count", dn_pulses - d0, 1);
    check("bounce dn edge", last_dn_cyc - base, 11);
    key_dn_raw = 1'b1;
    tick(30);

    // Simultaneous press: conflict timing
    u0 = up_pulses; d0 = dn_pulses;
    key_up_raw = 1'b0; key_dn_raw = 1'b0;
    tick(10);
    check("simul conflict@10", int'(conflict), 0);
    tick(1);
    check("simul conflict@11", int'(conflict), 1);
    tick(20);
    key_up_raw = 1'b1; key_dn_raw = 1'b1;
    tick(30);
    check("simul pulses", (up_pulses - u0) + (dn_pulses - d0), 0);

    // Table-driven phases
    for (int i = 0; i < 14; i++) begin
      u0 = up_pulses; d0 = dn_pulses;
      key_up_raw = tbl[i].up_raw;
      key_dn_raw = tbl[i].dn_raw;
      tick(tbl[i].cycles);
      check($sformatf("row%0d up pulses", i), up_pulses - u0, tbl[i].exp_up_p);
      check($sformatf("row%0d dn pulses", i), dn_pulses - d0, tbl[i].exp_dn_p);
      check($sformatf("row%0d up_level", i), int'(up_level), int'(tbl[i].exp_up_lvl));
      check($sformatf("row%0d dn_level", i), int'(dn_level), int'(tbl[i].exp_dn_lvl));
      check($sformatf("row%0d conflict", i), int'(conflict), int'(tbl[i].exp_conf));
    end

    // Reset mid-debounce, button held through reset
    u0 = up_pulses;
    key_up_raw = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(2);
    check("rst-db up_level", int'(up_level), 0);
    check("rst-db no pulse", up_pulses - u0, 0);
    reset = 1'b0; base2 = cyc;
    tick(15);
    check("rst-db count", up_pulses - u0, 1);
    check("rst-db edge", last_up_cyc - base2, 11);
    key_up_raw = 1'b1;
    tick(30);

    // Reset landing on the pulse edge aborts it
    u0 = up_pulses;
    key_up_raw = 1'b0;
    tick(10);
    reset = 1'b1;
    tick(1);
    check("rst-pulse out", int'(pb_seq_up), 0);
    check("rst-pulse level", int'(up_level), 0);
    tick(1);
    reset = 1'b0; base2 = cyc;
    tick(15);
    check("rst-pulse count", up_pulses - u0, 1);
    check("rst-pulse edge", last_up_cyc - base2, 11);
    key_up_raw = 1'b1;
    tick(30);

    // Long hold: repeats only with the optional feature
    u0 = up_pulses;
    key_up_raw = 1'b0; base = cyc;
    tick(50);
    check("hold pulse@50", int'(pb_seq_up), 0);
    tick(1);
    check("hold pulse@51", int'(pb_seq_up), AR ? 1 : 0);
    tick(49);
    key_up_raw = 1'b1;
    tick(40);
    check("hold count", up_pulses - u0, AR ? 7 : 1);
    check("hold last edge", last_up_cyc - base, AR ? 101 : 11);

    check("pulse width", wide_cnt, 0);
    check("never both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
